// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [6:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit: one-cycle multiply, restoring radix-2 divide,
// one-hot op select, valid/ready on both sides and a synchronous flush.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  output logic          busy,
  mul_div_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH + 2;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [6:0]         op_q, op_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d, rem_q, rem_d, quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               in_signed, in_onehot;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               mul_signed;
  logic [PW-1:0]      a_wide, b_wide, prod;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     shifted, trial;
  logic               div_signed, want_quo;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_res;

  // Datapath: operand magnitudes, widened product, one restoring step, sign fix-up
  always_comb begin
    in_signed  = bus.op[3] | bus.op[4];
    in_onehot  = $onehot(bus.op);
    a_mag      = (in_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag      = (in_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

    mul_signed = op_q[0] | op_q[1];
    a_wide     = {{(WIDTH+2){mul_signed & a_q[WIDTH-1]}}, a_q};
    b_wide     = {{(WIDTH+2){mul_signed & b_q[WIDTH-1]}}, b_q};
    prod       = a_wide * b_wide;
    if (!$onehot(op_q))
      mul_res = '0;
    else if (op_q[0])
      mul_res = prod[WIDTH-1:0];
    else
      mul_res = prod[2*WIDTH-1:WIDTH];

    shifted    = {rem_q, quo_q[WIDTH-1]};
    trial      = shifted - {1'b0, dvsr_q};

    div_signed = op_q[3] | op_q[4];
    want_quo   = op_q[3] | op_q[5];
    q_fix      = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix      = (div_signed && a_q[WIDTH-1]) ? (~rem_q + WIDTH'(1)) : rem_q;
    if (b_q == '0)
      fix_res = want_quo ? '1 : a_q;
    else
      fix_res = want_quo ? q_fix : r_fix;
  end

  // Next-state and register-input logic
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    dvsr_d     = dvsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          a_d    = bus.a;
          b_d    = bus.b;
          op_d   = bus.op;
          dvsr_d = b_mag;
          quo_d  = a_mag;
          rem_d  = '0;
          cnt_d  = CNT_W'(WIDTH - 1);
          if (!in_onehot || (bus.op[2:0] != 3'b000))
            state_d = MUL;
          else if (bus.b == '0)
            state_d = FIX;  // divide by zero skips iteration; FIX supplies the fixed result
          else
            state_d = DIV;
        end
      end
      MUL: begin
        out_data_d = mul_res;
        state_d    = DONE;
      end
      DIV: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0)
          state_d = FIX;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        out_data_d = fix_res;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush)
      state_d = IDLE;

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

endmodule
